obf_key_loader: RTL and testbench

- Upstream key-delivery stage for the key-gated c432 netlist.
- Receives the 12-bit activation key bit-serially from secure key storage and checks it with an even-parity bit.
- On a good check, drives the key-gate select inputs s_0..s_11 through key_out[0..11]; bit i drives s_i.
- Drives all zeros whenever no verified key is held, so a partial or wrong key never reaches the logic cone.

---
 rtl/obf_key_loader_pkg.sv | 20 ++
 rtl/obf_key_loader_if.sv | 24 ++
 rtl/obf_key_loader.sv | 120 ++++++++++++
 tb/tb_obf_key_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/obf_key_loader_pkg.sv
// Shared types and helpers for the c432 key loader and anything that builds key streams for it.
package obf_key_pkg;

    localparam int KEY_W_DEFAULT     = 12;
    localparam int MAX_RETRY_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Even parity: the bit that makes the total count of ones (key plus parity) even.
    function automatic logic even_parity(input logic [KEY_W_DEFAULT-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/obf_key_loader_if.sv
// Key-storage side handshake and key-gate outputs of the loader.
interface obf_key_loader_if #(
    parameter int KEY_W = obf_key_pkg::KEY_W_DEFAULT
);
    logic             start;
    logic             clear;
    logic             kbit_in;
    logic             kbit_valid;
    logic             kbit_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_err;
    logic             busy;

    modport master (
        output start, clear, kbit_in, kbit_valid,
        input  kbit_ready, key_out, key_valid, key_err, busy
    );

    modport slave (
        input  start, clear, kbit_in, kbit_valid,
        output kbit_ready, key_out, key_valid, key_err, busy
    );
endinterface

// File: rtl/obf_key_loader.sv
// Serial activation-key loader: shifts in KEY_W bits plus even parity and releases the key
// to the key-gate selects only after a good check; a few bad checks lock it out until reset.
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int  KEY_W     = KEY_W_DEFAULT,
    parameter int  MAX_RETRY = MAX_RETRY_DEFAULT,
    localparam int CNT_W     = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    obf_key_loader_if.slave  bus
);

    localparam int              RTY_W = $clog2(MAX_RETRY + 1);
    localparam int              IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W);

    state_t             state, state_n;
    logic [KEY_W-1:0]   shadow;
    logic [CNT_W-1:0]   bit_cnt;
    logic [RTY_W-1:0]   retry_cnt, retry_inc;
    logic               parity;
    logic [KEY_W-1:0]   key_q;
    logic               key_valid_q, key_err_q, busy_q;
    logic               zeroize, restart, xfer, chk_pass, chk_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        zeroize   = 1'b0;
        restart   = 1'b0;
        xfer      = 1'b0;
        chk_pass  = 1'b0;
        chk_fail  = 1'b0;
        retry_inc = retry_cnt + 1'b1;
        // clear outranks everything except the lock-out, which only reset leaves
        if (bus.clear && state != ERROR) begin
            zeroize = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    restart = 1'b1;
                    state_n = LOAD;
                end
                LOAD: if (bus.kbit_valid) begin
                    xfer = 1'b1;
                    if (bit_cnt == LAST) state_n = CHECK;
                end
                CHECK: if (^shadow ^ parity) begin
                    chk_fail = 1'b1;
                    state_n  = (retry_inc == RTY_W'(MAX_RETRY)) ? ERROR : LOAD;
                end else begin
                    chk_pass = 1'b1;
                    state_n  = DONE;
                end
                DONE:    state_n = DONE;
                ERROR:   state_n = ERROR;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            bit_cnt     <= '0;
            retry_cnt   <= '0;
            parity      <= 1'b0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (zeroize) begin
                shadow      <= '0;
                bit_cnt     <= '0;
                retry_cnt   <= '0;
                key_q       <= '0;
                key_valid_q <= 1'b0;
            end
            if (restart || chk_fail) begin
                shadow  <= '0;
                bit_cnt <= '0;
            end
            if (chk_fail) retry_cnt <= retry_inc;
            if (xfer) begin
                if (bit_cnt != LAST) begin
                    shadow[bit_cnt[IDX_W-1:0]] <= bus.kbit_in;
                    bit_cnt                    <= bit_cnt + 1'b1;
                end else begin
                    parity <= bus.kbit_in;
                end
            end
            // key_out only ever moves together with key_valid, so an unverified key never leaks
            if (chk_pass) begin
                key_q       <= shadow;
                key_valid_q <= 1'b1;
            end
            if (state_n == ERROR) begin
                key_q       <= '0;
                key_valid_q <= 1'b0;
            end
            key_err_q <= (state_n == ERROR);
            busy_q    <= (state_n == LOAD) || (state_n == CHECK);
        end
    end

    assign bus.kbit_ready = (state == LOAD);
    assign bus.key_out    = key_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.key_err    = key_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// Directed bench for obf_key_loader: a table of full loads from reset plus hand-written
// sequences for lock-out, recovery, clear, async reset and ignored start.
module tb_obf_key_loader;
    import obf_key_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obf_key_loader_if #(.KEY_W(12)) bus ();

    obf_key_loader #(.KEY_W(12), .MAX_RETRY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] key;
        logic        par;
        int          gap;
        logic        exp_valid;
        logic [11:0] exp_key;
        logic        exp_busy;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.start      = 1'b0;
        bus.clear      = 1'b0;
        bus.kbit_in    = 1'b0;
        bus.kbit_valid = 1'b0;
        rst_n          = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        int gap;
        int w;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) tick;
        w = 0;
        while (!bus.kbit_ready && w < 50) begin
            tick;
            w++;
        end
        if (!bus.kbit_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL kbit_ready_wait: got 0 want 1 within 50 cycles");
        end
        bus.kbit_in    = b;
        bus.kbit_valid = 1'b1;
        tick;
        bus.kbit_valid = 1'b0;
        bus.kbit_in    = 1'b0;
    endtask

    task automatic load(input logic [11:0] key, input logic par, input int gap);
        for (int i = 0; i < 12; i++) send_bit(key[i], gap);
        send_bit(par, gap);
    endtask

    initial begin
        logic [11:0] k;

        vecs[0] = '{12'hA5C, 1'b0, 0, 1'b1, 12'hA5C, 1'b0, 1'b0};
        vecs[1] = '{12'hA5C, 1'b0, 5, 1'b1, 12'hA5C, 1'b0, 1'b0};
        vecs[2] = '{12'hFFF, 1'b0, 0, 1'b1, 12'hFFF, 1'b0, 1'b0};
        vecs[3] = '{12'h001, 1'b1, 3, 1'b1, 12'h001, 1'b0, 1'b0};
        vecs[4] = '{12'h001, 1'b0, 0, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[5] = '{12'h000, 1'b0, 0, 1'b1, 12'h000, 1'b0, 1'b0};
        vecs[6] = '{12'h800, 1'b1, 2, 1'b1, 12'h800, 1'b0, 1'b0};
        vecs[7] = '{12'hA5C, 1'b1, 0, 1'b0, 12'h000, 1'b1, 1'b1};

        do_reset;
        chk("reset_key_valid", 32'(bus.key_valid), 32'd0);
        chk("reset_key_out", 32'(bus.key_out), 32'd0);
        chk("reset_key_err", 32'(bus.key_err), 32'd0);
        chk("reset_kbit_ready", 32'(bus.kbit_ready), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            do_reset;
            pulse_start;
            load(vecs[v].key, vecs[v].par, vecs[v].gap);
            // one cycle after the parity transfer: CHECK, nothing released yet
            chk($sformatf("v%0d_check_ready", v), 32'(bus.kbit_ready), 32'd0);
            chk($sformatf("v%0d_check_valid", v), 32'(bus.key_valid), 32'd0);
            chk($sformatf("v%0d_check_key", v), 32'(bus.key_out), 32'd0);
            tick;
            chk($sformatf("v%0d_key_valid", v), 32'(bus.key_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_key_out", v), 32'(bus.key_out), 32'(vecs[v].exp_key));
            chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'(vecs[v].exp_busy));
            chk($sformatf("v%0d_ready", v), 32'(bus.kbit_ready), 32'(vecs[v].exp_ready));
            chk($sformatf("v%0d_err", v), 32'(bus.key_err), 32'd0);
        end

        // three bad parities lock the loader out
        do_reset;
        pulse_start;
        for (int r = 0; r < 3; r++) begin
            load(12'hA5C, 1'b1, 0);
            tick;
            chk($sformatf("lock%0d_valid", r), 32'(bus.key_valid), 32'd0);
            chk($sformatf("lock%0d_key", r), 32'(bus.key_out), 32'd0);
            chk($sformatf("lock%0d_ready", r), 32'(bus.kbit_ready), (r < 2) ? 32'd1 : 32'd0);
            chk($sformatf("lock%0d_err", r), 32'(bus.key_err), (r < 2) ? 32'd0 : 32'd1);
        end
        chk("lock_busy", 32'(bus.busy), 32'd0);
        pulse_start;
        tick;
        chk("lock_start_err", 32'(bus.key_err), 32'd1);
        chk("lock_start_ready", 32'(bus.kbit_ready), 32'd0);
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        tick;
        chk("lock_clear_err", 32'(bus.key_err), 32'd1);
        chk("lock_clear_busy", 32'(bus.busy), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("lock_rst_err", 32'(bus.key_err), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        // one failure, then a good key
        pulse_start;
        load(12'hA5C, 1'b1, 0);
        tick;
        load(12'hFFF, even_parity(12'hFFF), 0);
        tick;
        chk("recov_key_out", 32'(bus.key_out), 32'hFFF);
        chk("recov_valid", 32'(bus.key_valid), 32'd1);
        chk("recov_err", 32'(bus.key_err), 32'd0);

        // clear during bit 6 drops that bit and returns to IDLE
        do_reset;
        pulse_start;
        k = 12'hA5C;
        for (int i = 0; i < 6; i++) send_bit(k[i], 0);
        bus.kbit_in    = k[6];
        bus.kbit_valid = 1'b1;
        bus.clear      = 1'b1;
        tick;
        bus.kbit_valid = 1'b0;
        bus.clear      = 1'b0;
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_ready", 32'(bus.kbit_ready), 32'd0);
        chk("clr_key_out", 32'(bus.key_out), 32'd0);
        pulse_start;
        load(12'h001, 1'b1, 0);
        tick;
        chk("clr_reload_key", 32'(bus.key_out), 32'h001);
        chk("clr_reload_valid", 32'(bus.key_valid), 32'd1);

        // start in DONE is ignored
        pulse_start;
        tick;
        chk("done_start_key", 32'(bus.key_out), 32'h001);
        chk("done_start_valid", 32'(bus.key_valid), 32'd1);
        chk("done_start_busy", 32'(bus.busy), 32'd0);

        // clear in DONE zeroizes the released key
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        chk("done_clear_key", 32'(bus.key_out), 32'd0);
        chk("done_clear_valid", 32'(bus.key_valid), 32'd0);

        // async reset in DONE and mid-load, checked before the next clock edge
        pulse_start;
        load(12'h800, 1'b1, 0);
        tick;
        chk("pre_rst_valid", 32'(bus.key_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_done_valid", 32'(bus.key_valid), 32'd0);
        chk("rst_done_key", 32'(bus.key_out), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        pulse_start;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_load_busy", 32'(bus.busy), 32'd0);
        chk("rst_load_ready", 32'(bus.kbit_ready), 32'd0);
        chk("rst_load_valid", 32'(bus.key_valid), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
